inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous reset, active-low.
REQ-003 in_valid  input  1  source request carries a valid field set.
REQ-004 in_ready  output  1  encoder accepts the field set this cycle.
REQ-005 opcode  input  7  RV32I major opcode.
REQ-006 rd, rs1, rs2  input  5 each  register indices.
REQ-007 funct3  input  3;  funct7  input  7  function fields.
REQ-008 imm  input  32  signed immediate value to pack.
REQ-009 out_valid  output  1  inst_code holds an encoded instruction.
REQ-010 out_ready  input  1  sink accepts inst_code this cycle.
REQ-011 inst_code  output  32  encoded RV32I instruction word.
REQ-012 imm_err  output  1  immediate out of range for the format; qualified by out_valid.

Function
REQ-013 Transfer occurs on in_valid&&in_ready (input) and on out_valid&&out_ready (output); no other event moves data.
REQ-014 Two-stage pipeline: S1 registers fields and decodes the format; S2 assembles and holds inst_code/imm_err; accept-to-out_valid latency is exactly 2 cycles with no stall.
REQ-015 S2 loads when empty or draining (out_ready); S1 advances when S2 loads; in_ready = !S1_valid || S1 advancing (combinational, no dependency on in_valid).
REQ-016 Full throughput: one instruction per cycle while out_ready stays high.
REQ-017 out_valid && !out_ready: inst_code, imm_err, out_valid held stable until accepted.
REQ-018 Both stages full and stalled: in_ready=0; no field set is dropped or duplicated.
REQ-019 Format by opcode: 0000011/0010011/1100111 I; 0100011 S; 1100011 B; 1101111 J; any other opcode R.
REQ-020 I: {imm[11:0], rs1, funct3, rd, opcode}.
REQ-021 S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-022 B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-023 J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-024 R: {funct7, rs2, rs1, funct3, rd, opcode}; imm ignored, imm_err=0.
REQ-025 Fields unused by a format are ignored; out-of-range immediates are truncated to the packed bits, never saturated.
REQ-026 Simultaneous S2 drain and S1 advance in one cycle is legal and loses nothing.

Reset
REQ-027 rst_n low asynchronously clears S1/S2 valid: out_valid=0, inst_code=32'h0, imm_err=0, in_ready=1 immediately in reset.
REQ-028 Reset mid-operation discards all in-flight instructions; nothing is emitted for them after release.
REQ-029 First transfer possible on the first rising edge with rst_n high.

Configuration
REQ-030 Macro IMM_RANGE_CHECK_EN defined: imm_err=1 when I/S imm is not the sign extension of imm[11], B imm not the sign extension of imm[12] or imm[0]!=0, J imm not the sign extension of imm[20] or imm[0]!=0; computed in S1, carried aligned with its instruction.
REQ-031 IMM_RANGE_CHECK_EN undefined: imm_err constant 0, no check logic; inst_code identical in both builds.

Verification
REQ-032 opcode=0010011, rd=1, rs1=2, funct3=0, imm=32'hFFFFFFFF, out_ready=1 -> inst_code=32'hFFF10093 two cycles after accept, imm_err=0.
REQ-033 opcode=1100011, rs1=1, rs2=2, funct3=0, imm=32'hFFFFFFFC -> inst_code=32'hFE208EE3; imm=32'h00001002 with check enabled -> imm_err=1.
REQ-034 opcode=1101111, rd=1, imm=32'h00000800 -> inst_code=32'h001000EF; imm=32'h00100000 with check -> imm_err=1.
REQ-035 Stream 4 instructions with out_ready low 3 cycles mid-stream -> in_ready=0 once both stages full, outputs stable, all 4 emitted in order, none duplicated.
REQ-036 Assert rst_n low with 2 in flight -> out_valid=0 combinationally, in_ready=1; after release no stale instruction appears.

Source files
------------

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: two-stage valid/ready pipeline, fields in, 32-bit word out.
// Optional IMM_RANGE_CHECK_EN flags immediates that do not fit their format.
module inst_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] inst_code,
  output logic        imm_err
);

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_J
  } fmt_e;

  fmt_e        fmt_d;
  fmt_e        s1_fmt;
  logic        s1_valid;
  logic [6:0]  s1_op;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [2:0]  s1_f3;
  logic [6:0]  s1_f7;
  logic [20:0] s1_imm;
  logic [31:0] code_d;
  logic        s2_load;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  // Classify the incoming opcode into its encoding format.
  always_comb begin
    fmt_d = FMT_R;
    unique case (1'b1)
      (opcode == 7'b0000011),
      (opcode == 7'b0010011),
      (opcode == 7'b1100111): fmt_d = FMT_I;
      (opcode == 7'b0100011): fmt_d = FMT_S;
      (opcode == 7'b1100011): fmt_d = FMT_B;
      (opcode == 7'b1101111): fmt_d = FMT_J;
      default:                fmt_d = FMT_R;
    endcase
  end

  // Stage 1: capture fields and decoded format on input handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_fmt   <= FMT_R;
      s1_op    <= '0;
      s1_rd    <= '0;
      s1_rs1   <= '0;
      s1_rs2   <= '0;
      s1_f3    <= '0;
      s1_f7    <= '0;
      s1_imm   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_fmt <= fmt_d;
        s1_op  <= opcode;
        s1_rd  <= rd;
        s1_rs1 <= rs1;
        s1_rs2 <= rs2;
        s1_f3  <= funct3;
        s1_f7  <= funct7;
        s1_imm <= imm[20:0];
      end
    end
  end

  // Pack the stage-1 fields into the instruction word.
  always_comb begin
    code_d = {s1_f7, s1_rs2, s1_rs1, s1_f3, s1_rd, s1_op};
    unique case (s1_fmt)
      FMT_I: code_d = {s1_imm[11:0], s1_rs1, s1_f3,
                       s1_rd, s1_op};
      FMT_S: code_d = {s1_imm[11:5], s1_rs2, s1_rs1,
                       s1_f3, s1_imm[4:0], s1_op};
      FMT_B: code_d = {s1_imm[12], s1_imm[10:5], s1_rs2,
                       s1_rs1, s1_f3, s1_imm[4:1],
                       s1_imm[11], s1_op};
      FMT_J: code_d = {s1_imm[20], s1_imm[10:1],
                       s1_imm[11], s1_imm[19:12],
                       s1_rd, s1_op};
      default: code_d = {s1_f7, s1_rs2, s1_rs1,
                         s1_f3, s1_rd, s1_op};
    endcase
  end

  // Stage 2: hold the encoded word until the sink takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      inst_code <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) inst_code <= code_d;
    end
  end

`ifdef IMM_RANGE_CHECK_EN
  logic err_d;
  logic s1_err;
  logic s2_err;

  // Range check on the raw immediate, before truncation.
  always_comb begin
    err_d = 1'b0;
    unique case (fmt_d)
      FMT_I, FMT_S: err_d = imm[31:11] != {21{imm[11]}};
      FMT_B: err_d = (imm[31:12] != {20{imm[12]}}) || imm[0];
      FMT_J: err_d = (imm[31:20] != {12{imm[20]}}) || imm[0];
      default: err_d = 1'b0;
    endcase
  end

  // Error flag travels with its instruction through both stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_err <= 1'b0;
      s2_err <= 1'b0;
    end else begin
      if (in_ready && in_valid) s1_err <= err_d;
      if (s2_load && s1_valid) s2_err <= s1_err;
    end
  end

  assign imm_err = s2_err;
`else
  logic unused_imm;
  assign unused_imm = ^imm[31:21];
  assign imm_err    = 1'b0;
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized bench for inst_encoder against an arithmetic encoding model.
// Tracks in-flight instructions in a queue to predict handshakes and order.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] inst_code;
  logic        imm_err;

`ifdef IMM_RANGE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [31:0] code;
    logic        err;
    int          e;
  } item_t;

  item_t       q[$];
  int          nvec = 0;
  int          nerr = 0;
  int          cyc = 0;
  logic [31:0] nxt_code;
  logic        nxt_err;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_code;
  logic        hold_err;

  inst_encoder dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .inst_code(inst_code), .imm_err(imm_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // 0=R 1=I 2=S 3=B 4=J
  function automatic int fmt_of(input logic [6:0] op);
    if (op == 7'h03 || op == 7'h13 || op == 7'h67) return 1;
    if (op == 7'h23) return 2;
    if (op == 7'h63) return 3;
    if (op == 7'h6F) return 4;
    return 0;
  endfunction

  function automatic logic [31:0] ref_code();
    logic [31:0] u;
    logic [31:0] base;
    u = imm;
    base = (32'(funct3) << 12) | 32'(opcode);
    case (fmt_of(opcode))
      1: return ((u & 32'hFFF) << 20) | (32'(rs1) << 15)
                | (32'(rd) << 7) | base;
      2: return (((u >> 5) & 32'h7F) << 25) | (32'(rs2) << 20)
                | (32'(rs1) << 15) | ((u & 32'h1F) << 7) | base;
      3: return (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25)
                | (32'(rs2) << 20) | (32'(rs1) << 15)
                | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7)
                | base;
      4: return (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21)
                | (((u >> 11) & 1) << 20) | (((u >> 12) & 255) << 12)
                | (32'(rd) << 7) | 32'(opcode);
      default: return (32'(funct7) << 25) | (32'(rs2) << 20)
                | (32'(rs1) << 15) | (32'(rd) << 7) | base;
    endcase
  endfunction

  function automatic logic ref_err();
    int s;
    s = int'(imm);
    if (!CHK) return 1'b0;
    case (fmt_of(opcode))
      1, 2: return (s < -2048) || (s > 2047);
      3: return (s < -4096) || (s > 4095) || (s % 2 != 0);
      4: return (s < -(1 << 20)) || (s > (1 << 20) - 1)
                || (s % 2 != 0);
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_fields(input logic [6:0] op,
                            input logic [4:0] d,
                            input logic [4:0] a,
                            input logic [4:0] b,
                            input logic [2:0] f3,
                            input logic [6:0] f7,
                            input logic [31:0] im);
    opcode = op; rd = d; rs1 = a; rs2 = b;
    funct3 = f3; funct7 = f7; imm = im;
    nxt_code = ref_code();
    nxt_err = ref_err();
  endtask

  task automatic rand_fields();
    logic [6:0] op;
    logic [31:0] im;
    case ($urandom_range(0, 7))
      0: op = 7'h03;
      1: op = 7'h13;
      2: op = 7'h67;
      3: op = 7'h23;
      4: op = 7'h63;
      5: op = 7'h6F;
      default: op = 7'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0: im = $urandom;
      1: im = 32'($urandom_range(0, 4095)) - 32'd2048;
      2: im = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
      default: im = (32'($urandom_range(0, 2097151)) - 32'd1048576)
                    & ~32'd1;
    endcase
    set_fields(op, 5'($urandom), 5'($urandom), 5'($urandom),
               3'($urandom), 7'($urandom), im);
  endtask

  // One clock: drive, predict, check, then advance to next negedge.
  task automatic cycle(input logic iv, input logic ordy,
                       output logic acc);
    item_t it;
    logic  exp_ov;
    in_valid = iv;
    out_ready = ordy;
    #1;
    chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || ordy));
    exp_ov = (q.size() > 0) ? (cyc >= q[0].e + 1) : 1'b0;
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (hold_pend) begin
      chk("hold_code", inst_code, hold_code);
      chk("hold_err", 32'(imm_err), 32'(hold_err));
    end
    hold_pend = out_valid && !ordy;
    hold_code = inst_code;
    hold_err = imm_err;
    if (out_valid && ordy && q.size() > 0) begin
      it = q.pop_front();
      chk("inst_code", inst_code, it.code);
      chk("imm_err", 32'(imm_err), 32'(it.err));
    end
    acc = iv && in_ready;
    if (acc) begin
      it.code = nxt_code;
      it.err = nxt_err;
      it.e = cyc + 1;
      q.push_back(it);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_inst_code", inst_code, 32'd0);
    chk("rst_imm_err", 32'(imm_err), 32'd0);
    q.delete();
    hold_pend = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push_one(input logic ordy);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      cycle(1'b1, ordy, acc);
      n++;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, acc);
  endtask

  initial begin
    logic acc;
    int   t;
    #3;
    chk("init_out_valid", 32'(out_valid), 32'd0);
    chk("init_in_ready", 32'(in_ready), 32'd1);
    chk("init_inst_code", inst_code, 32'd0);
    chk("init_imm_err", 32'(imm_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed encodings with known words.
    set_fields(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
    nxt_code = 32'hFFF10093; nxt_err = 1'b0;
    push_one(1'b1);
    drain(3);
    set_fields(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC);
    nxt_code = 32'hFE208EE3; nxt_err = 1'b0;
    push_one(1'b1);
    set_fields(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h00001002);
    nxt_code = 32'h80208163; nxt_err = CHK;
    push_one(1'b1);
    set_fields(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800);
    nxt_code = 32'h001000EF; nxt_err = 1'b0;
    push_one(1'b1);
    set_fields(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000);
    nxt_code = 32'h800000EF; nxt_err = CHK;
    push_one(1'b1);
    drain(3);

    // Four-instruction stream with a three-cycle sink stall.
    t = 0;
    for (int k = 0; k < 4; k++) begin
      rand_fields();
      acc = 1'b0;
      while (!acc && t < 30) begin
        cycle(1'b1, !(t >= 2 && t <= 4), acc);
        t++;
      end
    end
    drain(4);
    chk("stream_empty", 32'(q.size()), 32'd0);

    // Reset with two instructions in flight.
    rand_fields();
    push_one(1'b0);
    rand_fields();
    push_one(1'b0);
    do_reset();
    drain(4);

    // Random traffic with random sink backpressure.
    for (int i = 0; i < 3000; i++) begin
      rand_fields();
      if (i == 1500 && q.size() >= 1) do_reset();
      else cycle($urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0, acc);
    end
    drain(4);
    chk("final_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
